// File: rtl/shreg_pkg.sv
// shreg_pkg: shared encodings for the 4-bit rotate/load register and its sequencer.
//   - Op / S encodings (same code drives the register mode select)
//   - Sequencer state encodings
//   - Register width and the register's next-state function
package shreg_pkg;

    localparam int unsigned SHREG_W = 4;
    localparam int unsigned CNT_W   = 4;

    // Op and S encodings
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b01;
    localparam logic [1:0] OP_ROR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    // Value the register holds after one edge with mode s, current contents q, data d.
    function automatic logic [SHREG_W-1:0] shreg_next(
        input logic [1:0]         s,
        input logic [SHREG_W-1:0] q,
        input logic [SHREG_W-1:0] d
    );
        logic [SHREG_W-1:0] r;
        case (s)
            OP_ROL:  r = {q[SHREG_W-2:0], q[SHREG_W-1]};
            OP_ROR:  r = {q[0], q[SHREG_W-1:1]};
            OP_LOAD: r = d;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shreg_shadow.sv
// shreg_shadow: mirror of the downstream rotate/load register plus a valid bit.
// Ports:
//   CLK, RST_N  - clock, synchronous active-low reset
//   S, D, OE    - the same mode/data/output-enable the register sees
//   SHADOW      - expected register contents
//   SHADOW_VLD  - SHADOW is known-good (cleared whenever the register latches z)
module shreg_shadow
    import shreg_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [1:0]         S,
    input  logic [SHREG_W-1:0] D,
    input  logic               OE,
    output logic [SHREG_W-1:0] SHADOW,
    output logic               SHADOW_VLD
);

    logic [SHREG_W-1:0] shadow_q, shadow_d;
    logic               vld_q, vld_d;

    always_comb begin
        shadow_d = shreg_next(S, shadow_q, D);
        vld_d    = vld_q;
        if (S == OP_LOAD) begin
            vld_d = 1'b1;
        end
        // A tri-stated edge makes the register capture z, so the mirror is no longer trusted.
        if (OE) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shadow_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            vld_q    <= vld_d;
        end
    end

    assign SHADOW     = shadow_q;
    assign SHADOW_VLD = vld_q;

endmodule

// File: rtl/shreg_seq_ctrl.sv
// shreg_seq_ctrl: command sequencer for the 4-bit rotate/load register.
// Accepts one command (no-op / rotate left / rotate right / load) over valid/ready,
// drives S, D and OE for exactly the cycles needed, then pulses DONE.
// Ports:
//   CLK, RST_N                     - clock, synchronous active-low reset
//   CMD_VALID, CMD_READY           - command handshake (ready only in IDLE)
//   CMD_OP, CMD_CNT, CMD_DATA      - op code, rotate steps, load value
//   TRI_REQ                        - request to tri-state the register output
//   S, D, OE                       - registered controls to the register (OE=1 tri-state)
//   BUSY, DONE                     - busy in RUN/FIN, one-cycle completion pulse
//   SHADOW, SHADOW_VLD             - expected register contents and its validity
module shreg_seq_ctrl
    import shreg_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [CNT_W-1:0]   CMD_CNT,
    input  logic [SHREG_W-1:0] CMD_DATA,
    input  logic               TRI_REQ,
    output logic [1:0]         S,
    output logic [SHREG_W-1:0] D,
    output logic               OE,
    output logic               BUSY,
    output logic               DONE,
    output logic [SHREG_W-1:0] SHADOW,
    output logic               SHADOW_VLD
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         s_q, s_d;
    logic [SHREG_W-1:0] d_q, d_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               zero_work;

    // No-op and zero-step rotates skip RUN entirely; load always runs exactly one step.
    assign zero_work = (CMD_OP == OP_HOLD) || ((CMD_OP != OP_LOAD) && (CMD_CNT == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        d_d     = d_q;
        s_d     = OP_HOLD;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                oe_d   = TRI_REQ;
                busy_d = 1'b0;
                if (CMD_VALID) begin
                    op_d   = CMD_OP;
                    d_d    = CMD_DATA;
                    busy_d = 1'b1;
                    if (zero_work) begin
                        cnt_d   = '0;
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = (CMD_OP == OP_LOAD) ? CNT_W'(1) : CMD_CNT;
                        state_d = ST_RUN;
                        s_d     = CMD_OP;
                        oe_d    = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                // TRI_REQ is ignored here; it is resampled in FIN for the first IDLE cycle.
                oe_d = 1'b0;
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    s_d   = op_q;
                end
            end
            ST_FIN: begin
                oe_d    = TRI_REQ;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            s_q     <= OP_HOLD;
            d_q     <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            s_q     <= s_d;
            d_q     <= d_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign CMD_READY = (state_q == ST_IDLE);
    assign S         = s_q;
    assign D         = d_q;
    assign OE        = oe_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

    // Mirror sees the same registered controls as the register, so it updates on the same edge.
    shreg_shadow u_shadow (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .S          (s_q),
        .D          (d_q),
        .OE         (oe_q),
        .SHADOW     (SHADOW),
        .SHADOW_VLD (SHADOW_VLD)
    );

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Self-checking bench for shreg_seq_ctrl: table of commands with hand-computed results,
// plus directed sequences for tri-state and mid-command reset.
module tb_shreg_seq_ctrl;
    import shreg_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_OP = 2'b00;
    logic [3:0] CMD_CNT = 4'd0;
    logic [3:0] CMD_DATA = 4'd0;
    logic       TRI_REQ = 1'b0;
    logic [1:0] S;
    logic [3:0] D;
    logic       OE;
    logic       BUSY;
    logic       DONE;
    logic [3:0] SHADOW;
    logic       SHADOW_VLD;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    shreg_seq_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_OP     (CMD_OP),
        .CMD_CNT    (CMD_CNT),
        .CMD_DATA   (CMD_DATA),
        .TRI_REQ    (TRI_REQ),
        .S          (S),
        .D          (D),
        .OE         (OE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .SHADOW     (SHADOW),
        .SHADOW_VLD (SHADOW_VLD)
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        logic [3:0] data;
        int         exp_s;      // cycles S shows the op
        int         exp_busy;   // cycles BUSY high (= cycles CMD_READY low)
        logic [3:0] exp_shadow;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Issue one command and observe it until CMD_READY returns (bounded).
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [3:0] data,
                           output int rdy0, output int s_cyc, output int bad_s,
                           output int busy_cyc, output int nrdy, output int done_cnt,
                           output int oe_run, output int d_bad, output int timeout);
        rdy0 = 0; s_cyc = 0; bad_s = 0; busy_cyc = 0; nrdy = 0;
        done_cnt = 0; oe_run = 0; d_bad = 0; timeout = 1;
        @(negedge CLK);
        rdy0      = int'(CMD_READY);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_CNT   = cnt;
        CMD_DATA  = data;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (CMD_READY) begin
                timeout = 0;
                break;
            end
            nrdy++;
            if (BUSY) busy_cyc++;
            if (DONE) done_cnt++;
            if (S != 2'b00) begin
                if (S == op) s_cyc++;
                else bad_s++;
                if (OE) oe_run++;
                if (D != data) d_bad++;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        int rdy0, s_cyc, bad_s, busy_cyc, nrdy, done_cnt, oe_run, d_bad, timeout;
        int done_seen;
        string nm;

        vecs[0] = '{OP_LOAD, 4'd0,  4'b1001, 1,  2,  4'b1001, 1'b1};
        vecs[1] = '{OP_LOAD, 4'd9,  4'b0001, 1,  2,  4'b0001, 1'b1};
        vecs[2] = '{OP_ROL,  4'd3,  4'b0000, 3,  4,  4'b1000, 1'b1};
        vecs[3] = '{OP_LOAD, 4'd0,  4'b0110, 1,  2,  4'b0110, 1'b1};
        vecs[4] = '{OP_ROR,  4'd15, 4'b0000, 15, 16, 4'b1100, 1'b1};
        vecs[5] = '{OP_ROR,  4'd0,  4'b0000, 0,  1,  4'b1100, 1'b1};
        vecs[6] = '{OP_HOLD, 4'd7,  4'b1111, 0,  1,  4'b1100, 1'b1};
        vecs[7] = '{OP_ROL,  4'd5,  4'b1111, 5,  6,  4'b1001, 1'b1};
        vecs[8] = '{OP_LOAD, 4'd7,  4'b1010, 1,  2,  4'b1010, 1'b1};
        vecs[9] = '{OP_ROR,  4'd1,  4'b0000, 1,  2,  4'b0101, 1'b1};

        // Reset state
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_ready", int'(CMD_READY), 1);
        chk("rst_s", int'(S), 0);
        chk("rst_d", int'(D), 0);
        chk("rst_oe", int'(OE), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_shadow", int'(SHADOW), 0);
        chk("rst_vld", int'(SHADOW_VLD), 0);

        // Table-driven commands
        for (int v = 0; v < 10; v++) begin
            run_cmd(vecs[v].op, vecs[v].cnt, vecs[v].data,
                    rdy0, s_cyc, bad_s, busy_cyc, nrdy, done_cnt, oe_run, d_bad, timeout);
            nm = $sformatf("v%0d", v);
            chk({nm, "_ready_at_accept"}, rdy0, 1);
            chk({nm, "_timeout"}, timeout, 0);
            chk({nm, "_s_cycles"}, s_cyc, vecs[v].exp_s);
            chk({nm, "_s_wrong"}, bad_s, 0);
            chk({nm, "_busy_cycles"}, busy_cyc, vecs[v].exp_busy);
            chk({nm, "_notready_cycles"}, nrdy, vecs[v].exp_busy);
            chk({nm, "_done_pulses"}, done_cnt, 1);
            chk({nm, "_oe_in_run"}, oe_run, 0);
            if (vecs[v].op == OP_LOAD) chk({nm, "_d_during_load"}, d_bad, 0);
            chk({nm, "_shadow"}, int'(SHADOW), int'(vecs[v].exp_shadow));
            chk({nm, "_vld"}, int'(SHADOW_VLD), int'(vecs[v].exp_vld));
        end

        // Tri-state request in IDLE, rotate while invalid, then load revalidates
        @(negedge CLK);
        TRI_REQ = 1'b1;
        @(negedge CLK);
        chk("tri_oe_next_cycle", int'(OE), 1);
        @(negedge CLK);
        chk("tri_vld_cleared", int'(SHADOW_VLD), 0);
        run_cmd(OP_ROL, 4'd1, 4'b0000,
                rdy0, s_cyc, bad_s, busy_cyc, nrdy, done_cnt, oe_run, d_bad, timeout);
        chk("tri_rol_timeout", timeout, 0);
        chk("tri_rol_s_cycles", s_cyc, 1);
        chk("tri_rol_oe_forced_low", oe_run, 0);
        chk("tri_rol_shadow", int'(SHADOW), 4'b1010);
        chk("tri_rol_vld_stays_low", int'(SHADOW_VLD), 0);
        chk("tri_oe_back_in_idle", int'(OE), 1);
        TRI_REQ = 1'b0;
        run_cmd(OP_LOAD, 4'd0, 4'b0011,
                rdy0, s_cyc, bad_s, busy_cyc, nrdy, done_cnt, oe_run, d_bad, timeout);
        chk("tri_load_timeout", timeout, 0);
        chk("tri_load_shadow", int'(SHADOW), 4'b0011);
        chk("tri_load_vld", int'(SHADOW_VLD), 1);

        // Reset during step 2 of a 5-step rotate; held CMD_VALID must not be taken while busy
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = OP_ROL;
        CMD_CNT   = 4'd5;
        CMD_DATA  = 4'b0000;
        @(negedge CLK);
        CMD_OP    = OP_LOAD;
        CMD_DATA  = 4'b1111;
        chk("abort_step1_s", int'(S), int'(OP_ROL));
        chk("abort_step1_ready", int'(CMD_READY), 0);
        @(negedge CLK);
        chk("abort_step2_s", int'(S), int'(OP_ROL));
        chk("abort_step2_d", int'(D), 0);
        chk("abort_step2_shadow", int'(SHADOW), 4'b0110);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_s", int'(S), 0);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_done", int'(DONE), 0);
        chk("abort_shadow", int'(SHADOW), 0);
        chk("abort_vld", int'(SHADOW_VLD), 0);
        chk("abort_ready", int'(CMD_READY), 1);
        CMD_VALID = 1'b0;
        RST_N     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (DONE) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_idle_s", int'(S), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
